// File: rtl/mem_access_unit.sv
// Load/store unit with byte/half/word access, sign/zero extension and read-modify-write for sub-word stores.
// Latency: error 1, word store 2, load 3, sub-word store 4 cycles to done; requests are not accepted while busy.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_CAP  = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]  state;
  logic        l_we;
  logic        l_sext;
  logic [1:0]  l_size;
  logic [1:0]  l_lane;
  logic [15:0] l_wdata;

  logic        misaligned;
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign misaligned = (size == 2'b11) |
                      ((size == 2'b01) & addr[0]) |
                      ((size == 2'b10) & (addr[1:0] != 2'b00));

  // Lane shift amounts in bits; little-endian lane k sits at bit 8k.
  assign bsh   = {l_lane, 3'b000};
  assign hsh   = {l_lane[1], 4'b0000};
  assign sel_b = mem_rdata[bsh +: 8];
  assign sel_h = mem_rdata[hsh +: 16];

  always_comb begin
    load_val = mem_rdata;
    merged   = mem_rdata;
    case (l_size)
      2'b00: begin
        load_val = {{24{l_sext & sel_b[7]}}, sel_b};
        merged   = (mem_rdata & ~(32'h0000_00ff << bsh)) | ({24'h0, l_wdata[7:0]} << bsh);
      end
      2'b01: begin
        load_val = {{16{l_sext & sel_h[15]}}, sel_h};
        merged   = (mem_rdata & ~(32'h0000_ffff << hsh)) | ({16'h0, l_wdata} << hsh);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      l_we      <= 1'b0;
      l_sext    <= 1'b0;
      l_size    <= 2'b00;
      l_lane    <= 2'b00;
      l_wdata   <= 16'h0;
      rdata     <= 32'h0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            l_we     <= we;
            l_sext   <= sign_ext;
            l_size   <= size;
            l_lane   <= addr[1:0];
            l_wdata  <= wdata[15:0];
            busy     <= 1'b1;
            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (we && (size == 2'b10)) begin
              // Full-word store needs no read, so it goes straight to the write.
              state     <= WR;
              mem_wr    <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: state <= RD_CAP;
        RD_CAP: begin
          if (l_we) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            state     <= WR;
          end else begin
            rdata <= load_val;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        WR: begin
          mem_wr <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done   <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
          mem_wr <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 req  input  1  access request from control unit; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 size  input  2  00 byte (LB/SB), 01 half (LH/SH), 10 word (LW/SW), 11 reserved.
REQ-007 sign_ext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  input  ADDR_W  byte address of access.
REQ-009 wdata  input  32  store data, right-justified.
REQ-010 rdata  output  32  load result, extended; held until next load completes.
REQ-011 done  output  1  one-cycle pulse marking end of an accepted request.
REQ-012 err  output  1  with done: misaligned or reserved-size request, no memory write.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mem_addr  output  ADDR_W  word-aligned memory address, {addr[ADDR_W-1:2],2'b00}.
REQ-015 mem_wr  output  1  memory write strobe, one cycle per store.
REQ-016 mem_wdata  output  32  full word written to memory.
REQ-017 mem_rdata  input  32  memory read data, valid the cycle after mem_addr is presented with mem_wr=0.

Function
REQ-018 All outputs registered; states IDLE, RD_WAIT, RD_CAP, WR, DONE.
REQ-019 IDLE, req=1 (cycle N): latch we, size, sign_ext, addr, wdata; later changes to the inputs are ignored.
REQ-020 Misaligned = (size=01 & addr[0]) | (size=10 & addr[1:0]!=0) | size=11; if set -> DONE with done=1, err=1 in N+1; mem_wr stays 0.
REQ-021 Word store -> WR: mem_addr, mem_wdata=wdata, mem_wr=1 in N+1; done=1 in N+2.
REQ-022 Load or byte/half store -> RD_WAIT: mem_addr driven, mem_wr=0 in N+1; RD_CAP samples mem_rdata at end of N+2.
REQ-023 Load completion: rdata updated and done=1 in N+3 -> IDLE.
REQ-024 Byte/half store: RD_CAP merges wdata low byte/half into read word at lane addr[1:0] (byte) or addr[1] (half); other lanes unchanged; WR mem_wr=1 in N+3; done=1 in N+4.
REQ-025 Little-endian lanes: byte k = bits [8k+7:8k]; half h = bits [16h+15:16h].
REQ-026 Load extraction: selected byte/half right-justified; upper bits = sign bit if sign_ext=1, else 0; word loads ignore sign_ext.
REQ-027 done and err are high for exactly one cycle; err=0 on successful completions.
REQ-028 req while busy=1 is ignored (not queued); req held high in the done cycle is accepted only on return to IDLE (cycle after done).
REQ-029 mem_wr is 1 only in WR state; never two consecutive cycles.
REQ-030 rdata unchanged by stores and by error completions.

Reset
REQ-031 reset=0 immediately forces IDLE; done=0, err=0, busy=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0.
REQ-032 Reset asserted mid-operation aborts it: no mem_wr pulse, no done, even if reset falls in RD_CAP or WR.
REQ-033 After reset deasserts, first req sampled on the first rising edge with reset=1.

Verification
REQ-034 LB addr=0x103, sign_ext=1, memory[0x100]=0x80FF1234 -> done in N+3, rdata=0xFFFFFF80.
REQ-035 LH addr=0x102, sign_ext=0, same word -> rdata=0x000080FF; LW addr=0x100 -> rdata=0x80FF1234.
REQ-036 SB addr=0x101, wdata=0xAABBCCDD, memory[0x100]=0x11223344 -> single mem_wr in N+3, mem_wdata=0x1122DD44, done in N+4.
REQ-037 SW addr=0x102 (misaligned) -> done=1, err=1 in N+1, mem_wr never 1, memory unchanged.
REQ-038 SH addr=0x200 started, reset=0 asserted during RD_CAP -> no mem_wr, no done, all outputs at reset values; next LW after release completes normally.
REQ-039 Back-to-back: req held high across two word stores -> second accepted the cycle after first done; exactly two mem_wr pulses.
